star_hub_router: RTL

Parametrised central switch for the star topology: N_PORTS leaf nodes each feed flits into a per-port input FIFO. The router decodes each head flit's destination field, arbitrates round-robin per output port, and delivers flits through a registered valid/ready output stage. It replaces the fixed 4-port, free-running-enable hub with real flow control, contention handling and illegal-destination dropping.

---
 rtl/star_hub_router_if.sv | 24 ++
 rtl/star_hub_router.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/star_hub_router_if.sv
// Flit-side bundle of the star hub: per-port input handshake, per-port output
// handshake and the drop counter. The router takes the slave view.
interface star_hub_router_if #(
    parameter int N_PORTS = 4,
    parameter int FLIT_W  = 64
);
    logic [N_PORTS-1:0]        in_valid;
    logic [N_PORTS*FLIT_W-1:0] in_flit;
    logic [N_PORTS-1:0]        in_ready;
    logic [N_PORTS-1:0]        out_valid;
    logic [N_PORTS*FLIT_W-1:0] out_flit;
    logic [N_PORTS-1:0]        out_ready;
    logic [15:0]               drop_cnt;

    modport master (
        output in_valid, in_flit, out_ready,
        input  in_ready, out_valid, out_flit, drop_cnt
    );

    modport slave (
        input  in_valid, in_flit, out_ready,
        output in_ready, out_valid, out_flit, drop_cnt
    );
endinterface

// File: rtl/star_hub_router.sv
// Star hub: per-port input FIFOs, head-flit destination decode, round-robin
// arbitration per output, one-flit registered output stage and a saturating
// count of flits dropped for an out-of-range destination.
module star_hub_router #(
    parameter int N_PORTS = 4,
    parameter int FLIT_W  = 64,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    star_hub_router_if.slave bus
);
    localparam int PW = $clog2(N_PORTS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Input FIFO storage and bookkeeping
    logic [FLIT_W-1:0]                mem_q [N_PORTS][DEPTH];
    logic [N_PORTS-1:0][AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [N_PORTS-1:0][AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [N_PORTS-1:0][CW-1:0]       cnt_q, cnt_d;
    logic [N_PORTS-1:0]               in_ready;
    logic [N_PORTS-1:0]               push;
    logic [N_PORTS-1:0]               pop;

    // Head decode
    logic [FLIT_W-1:0]                head [N_PORTS];
    logic [N_PORTS-1:0]               illegal;
    logic [N_PORTS-1:0][N_PORTS-1:0]  req;      // req[o][p]: head of p targets o
    logic [31:0]                      dest_w;
    logic                             legal;

    // Arbitration
    logic [N_PORTS-1:0]               out_free;
    logic [N_PORTS-1:0]               gnt_any;
    logic [N_PORTS-1:0][PW-1:0]       gnt_idx;
    logic [N_PORTS-1:0][PW-1:0]       rr_q, rr_d;
    int unsigned                      idx;

    // Output stage and drop counter
    logic [N_PORTS-1:0]               out_valid_q, out_valid_d;
    logic [N_PORTS*FLIT_W-1:0]        out_flit_q, out_flit_d;
    logic [15:0]                      drop_q, drop_d;
    logic [16:0]                      drop_sum;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_flit  = out_flit_q;
    assign bus.drop_cnt  = drop_q;
    assign out_free      = ~out_valid_q | bus.out_ready;

    // FIFO acceptance depends only on registered occupancy and reset
    always_comb begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            in_ready[p] = rst && (cnt_q[p] != CW'(DEPTH));
            push[p]     = bus.in_valid[p] && in_ready[p];
        end
    end

    // Decode each FIFO head into an output request or an illegal drop
    always_comb begin
        dest_w  = '0;
        legal   = 1'b0;
        illegal = '0;
        req     = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            head[p]    = mem_q[p][rd_ptr_q[p]];
            dest_w     = 32'(head[p][2*ADDR_W-1:ADDR_W]);
            legal      = dest_w < 32'(N_PORTS);
            illegal[p] = (cnt_q[p] != '0) && !legal;
            for (int unsigned o = 0; o < N_PORTS; o++) begin
                req[o][p] = (cnt_q[p] != '0) && legal && (dest_w == 32'(o));
            end
        end
    end

    // Round-robin grant per free output, search starting at rr_q
    always_comb begin
        gnt_any = '0;
        gnt_idx = '0;
        rr_d    = rr_q;
        idx     = 0;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            if (out_free[o]) begin
                for (int unsigned i = 0; i < N_PORTS; i++) begin
                    idx = 32'(rr_q[o]) + i;
                    if (idx >= N_PORTS) idx = idx - N_PORTS;
                    if (!gnt_any[o] && req[o][PW'(idx)]) begin
                        gnt_any[o] = 1'b1;
                        gnt_idx[o] = PW'(idx);
                    end
                end
                if (gnt_any[o]) begin
                    rr_d[o] = (gnt_idx[o] == PW'(N_PORTS - 1)) ? '0 : gnt_idx[o] + PW'(1);
                end
            end
        end
    end

    // Pops come from grants and illegal heads; an input has one target so
    // at most one output can grant it
    always_comb begin
        pop = illegal;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            if (gnt_any[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // FIFO pointer/occupancy next state
    always_comb begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + AW'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + AW'(pop[p]);
            cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
        end
    end

    // Output register load / drain and saturating drop count
    always_comb begin
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            if (gnt_any[o]) begin
                out_valid_d[o]                   = 1'b1;
                out_flit_d[o*FLIT_W +: FLIT_W]   = head[gnt_idx[o]];
            end else if (bus.out_ready[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
        drop_sum = 17'(drop_q);
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            drop_sum = drop_sum + 17'(illegal[p]);
        end
        drop_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rr_q        <= '0;
            out_valid_q <= '0;
            out_flit_q  <= '0;
            drop_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            drop_q      <= drop_d;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (push[p]) mem_q[p][wr_ptr_q[p]] <= bus.in_flit[p*FLIT_W +: FLIT_W];
        end
    end
endmodule
